// File: rtl/sysreg_irq_if.sv
// Bus bundle for sysreg_irq: system-register access, PC capture, ALU flags and interrupt handshake.
// The master modport is the core/CPU side; the slave modport is the sysreg_irq block.
interface sysreg_irq_if #(
  parameter int unsigned IRQ_CNT = 4,
  parameter int unsigned FLAGS_W = 5
);
  logic               sr_ie;
  logic [15:0]        sr_sel;
  logic [15:0]        sr_in;
  logic [15:0]        sr_out;
  logic [6:0]         instr_op;
  logic [15:0]        pc_in;
  logic               pc_ie;
  logic               pc_inc;
  logic               out_addr_ovr;
  logic [FLAGS_W-1:0] alu_flags_in;
  logic               alu_flags_ie;
  logic [FLAGS_W-1:0] alu_flags;
  logic [IRQ_CNT-1:0] irq_in;
  logic               irq_ack;
  logic               irq_req;
  logic [3:0]         irq_vec;
  logic               boot_mode;
  logic               instr_mem_over;
  logic               irq_en;

  modport master (
    output sr_ie, sr_sel, sr_in, instr_op, pc_in, pc_ie, pc_inc, out_addr_ovr,
    output alu_flags_in, alu_flags_ie, irq_in, irq_ack,
    input  sr_out, alu_flags, irq_req, irq_vec, boot_mode, instr_mem_over, irq_en
  );

  modport slave (
    input  sr_ie, sr_sel, sr_in, instr_op, pc_in, pc_ie, pc_inc, out_addr_ovr,
    input  alu_flags_in, alu_flags_ie, irq_in, irq_ack,
    output sr_out, alu_flags, irq_req, irq_vec, boot_mode, instr_mem_over, irq_en
  );
endinterface

// File: rtl/sysreg_irq.sv
// System registers plus edge-triggered, masked, lowest-index-first interrupt controller.
// Optional ALU flag save/restore across interrupts: define SYSREG_IRQ_FLAG_SAVE_EN.
module sysreg_irq #(
  parameter int unsigned IRQ_CNT = 4,
  parameter int unsigned FLAGS_W = 5
) (
  input logic         clk,
  input logic         rst,
  sysreg_irq_if.slave bus
);
  localparam logic [6:0] OpJtrLd  = 7'b0001110;
  localparam logic [6:0] OpIret   = 7'b0001111;
  localparam logic [6:0] OpJtrSel = 7'b0010001;

  typedef enum logic [1:0] {StIdle, StReq, StActive} state_e;

  state_e             state_q, state_d;
  logic [2:0]         rt_mode_q, rt_mode_d;  // {IRQEN, INA, SUP}
  logic               jtr_mode_q, jtr_mode_d, jtr_buff_q, jtr_buff_d;
  logic [15:0]        irq_pc_q, irq_pc_d;
  logic [FLAGS_W-1:0] alu_flags_q, alu_flags_d;
  logic [IRQ_CNT-1:0] irq_mask_q, irq_mask_d, irq_pend_q, irq_pend_d, irq_prev_q;
  logic [3:0]         irq_cause_q, irq_cause_d, irq_vec_q, irq_vec_d;
  logic [IRQ_CNT-1:0] pend_clr, eligible;
  logic [3:0]         first_irq;
  logic               enter, iret;
`ifdef SYSREG_IRQ_FLAG_SAVE_EN
  logic [FLAGS_W-1:0] flag_shadow_q, flag_shadow_d;
`endif

  assign eligible = irq_pend_q & irq_mask_q;

  always_comb begin
    first_irq = '0;
    for (int i = int'(IRQ_CNT) - 1; i >= 0; i--) begin
      if (eligible[i]) first_irq = 4'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    rt_mode_d   = rt_mode_q;
    jtr_mode_d  = jtr_mode_q;
    jtr_buff_d  = jtr_buff_q;
    irq_pc_d    = irq_pc_q;
    alu_flags_d = alu_flags_q;
    irq_mask_d  = irq_mask_q;
    irq_cause_d = irq_cause_q;
    irq_vec_d   = irq_vec_q;
    pend_clr    = '0;
    enter       = 1'b0;
    iret        = 1'b0;
`ifdef SYSREG_IRQ_FLAG_SAVE_EN
    flag_shadow_d = flag_shadow_q;
`endif

    if (bus.sr_ie) begin
      case (bus.sr_sel)
        16'd1:   if (rt_mode_q[0]) rt_mode_d = bus.sr_in[2:0];
        16'd2:   jtr_buff_d = bus.sr_in[0];
        16'd3:   irq_pc_d = bus.sr_in;
        16'd4:   alu_flags_d = bus.sr_in[FLAGS_W-1:0];
        16'd5:   irq_mask_d = bus.sr_in[IRQ_CNT-1:0];
        16'd6:   pend_clr = bus.sr_in[IRQ_CNT-1:0];
        default: ;
      endcase
    end
    if (bus.alu_flags_ie) alu_flags_d = bus.alu_flags_in;
    if (bus.out_addr_ovr) rt_mode_d[2] = 1'b1;
    if ((bus.instr_op == OpJtrLd) || (bus.instr_op == OpIret) ||
        ((bus.instr_op == OpJtrSel) && (bus.sr_sel == 16'd0))) begin
      jtr_mode_d = jtr_buff_q;
    end

    unique case (state_q)
      StIdle: begin
        if (rt_mode_q[2] && (|eligible)) begin
          state_d   = StReq;
          irq_vec_d = first_irq;
        end
      end
      StReq: begin
        // Software disabling interrupts withdraws an unacknowledged request.
        if (!rt_mode_q[2]) begin
          state_d = StIdle;
        end else if (bus.irq_ack) begin
          state_d = StActive;
          enter   = 1'b1;
        end
      end
      StActive: begin
        if (bus.instr_op == OpIret) begin
          state_d = StIdle;
          iret    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (enter) begin
      rt_mode_d[0] = 1'b1;
      rt_mode_d[2] = 1'b0;
      irq_cause_d  = irq_vec_q;
      if (bus.pc_ie)       irq_pc_d = bus.sr_in;
      else if (bus.pc_inc) irq_pc_d = bus.pc_in + 16'd1;
      else                 irq_pc_d = bus.pc_in;
`ifdef SYSREG_IRQ_FLAG_SAVE_EN
      flag_shadow_d = alu_flags_q;
`endif
    end
    if (iret) begin
      rt_mode_d[2] = 1'b1;
`ifdef SYSREG_IRQ_FLAG_SAVE_EN
      alu_flags_d = flag_shadow_q;
`endif
    end

    // Clears first, then new edges, so a same-cycle edge always survives.
    irq_pend_d = irq_pend_q & ~pend_clr;
    for (int i = 0; i < int'(IRQ_CNT); i++) begin
      if (enter && (irq_vec_q == 4'(i))) irq_pend_d[i] = 1'b0;
    end
    irq_pend_d = irq_pend_d | (bus.irq_in & ~irq_prev_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rt_mode_q   <= 3'b001;
      jtr_mode_q  <= 1'b1;
      jtr_buff_q  <= 1'b1;
      irq_pc_q    <= '0;
      alu_flags_q <= '0;
      irq_mask_q  <= '0;
      irq_pend_q  <= '0;
      irq_prev_q  <= '0;
      irq_cause_q <= '0;
      irq_vec_q   <= '0;
`ifdef SYSREG_IRQ_FLAG_SAVE_EN
      flag_shadow_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rt_mode_q   <= rt_mode_d;
      jtr_mode_q  <= jtr_mode_d;
      jtr_buff_q  <= jtr_buff_d;
      irq_pc_q    <= irq_pc_d;
      alu_flags_q <= alu_flags_d;
      irq_mask_q  <= irq_mask_d;
      irq_pend_q  <= irq_pend_d;
      irq_prev_q  <= bus.irq_in;
      irq_cause_q <= irq_cause_d;
      irq_vec_q   <= irq_vec_d;
`ifdef SYSREG_IRQ_FLAG_SAVE_EN
      flag_shadow_q <= flag_shadow_d;
`endif
    end
  end

  always_comb begin
    bus.sr_out = '0;
    if (bus.out_addr_ovr) begin
      bus.sr_out = irq_pc_q;
    end else begin
      case (bus.sr_sel)
        16'd1:   bus.sr_out = {13'd0, rt_mode_q};
        16'd2:   bus.sr_out = {15'd0, jtr_buff_q};
        16'd3:   bus.sr_out = irq_pc_q;
        16'd4:   bus.sr_out = 16'(alu_flags_q);
        16'd5:   bus.sr_out = 16'(irq_mask_q);
        16'd6:   bus.sr_out = 16'(irq_pend_q);
        16'd7:   bus.sr_out = {12'd0, irq_cause_q};
`ifdef SYSREG_IRQ_FLAG_SAVE_EN
        16'd8:   bus.sr_out = 16'(flag_shadow_q);
`endif
        default: bus.sr_out = '0;
      endcase
    end
  end

  assign bus.alu_flags      = alu_flags_q;
  assign bus.irq_req        = (state_q == StReq);
  assign bus.irq_vec        = irq_vec_q;
  assign bus.boot_mode      = jtr_mode_q;
  assign bus.instr_mem_over = rt_mode_q[1];
  assign bus.irq_en         = rt_mode_q[2];
endmodule

// File: tb/tb_sysreg_irq.sv
// Bench for sysreg_irq: directed vectors with literal expectations, plus a behavioural model
// compared against every output on each falling edge. Honours SYSREG_IRQ_FLAG_SAVE_EN.
module tb_sysreg_irq;
  logic clk;
  logic rst;

  sysreg_irq_if #(.IRQ_CNT(4), .FLAGS_W(5)) bus ();

  sysreg_irq #(.IRQ_CNT(4), .FLAGS_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [2:0]  m_rt;      // {IRQEN, INA, SUP}
  logic        m_jmode, m_jbuf;
  logic [15:0] m_pc;
  logic [4:0]  m_flags, m_shadow;
  logic [3:0]  m_mask, m_pend, m_cause, m_prev, m_vec;
  logic        m_req;     // request raised, waiting for ack
  logic        m_hnd;     // inside a handler
  bit          model_on = 0;

  function automatic logic [3:0] lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  task automatic model_update();
    logic       en, start, enter, leave, ret, jb;
    logic [3:0] first;
    logic [4:0] old_flags;
    if (rst) begin
      m_rt = 3'b001; m_jmode = 1'b1; m_jbuf = 1'b1; m_pc = '0; m_flags = '0; m_shadow = '0;
      m_mask = '0; m_pend = '0; m_cause = '0; m_prev = '0; m_vec = '0; m_req = 0; m_hnd = 0;
      return;
    end
    en        = m_rt[2];
    start     = !m_req && !m_hnd && en && ((m_pend & m_mask) != 4'd0);
    first     = lowest(m_pend & m_mask);
    leave     = m_req && !en;
    enter     = m_req && en && bus.irq_ack;
    ret       = m_hnd && (bus.instr_op == 7'b0001111);
    jb        = m_jbuf;
    old_flags = m_flags;
    if (bus.sr_ie) begin
      if (bus.sr_sel == 16'd1 && m_rt[0]) m_rt = bus.sr_in[2:0];
      if (bus.sr_sel == 16'd2) m_jbuf = bus.sr_in[0];
      if (bus.sr_sel == 16'd3) m_pc = bus.sr_in;
      if (bus.sr_sel == 16'd4) m_flags = bus.sr_in[4:0];
      if (bus.sr_sel == 16'd5) m_mask = bus.sr_in[3:0];
      if (bus.sr_sel == 16'd6) m_pend = m_pend & ~bus.sr_in[3:0];
    end
    if (bus.alu_flags_ie) m_flags = bus.alu_flags_in;
    if (bus.out_addr_ovr) m_rt[2] = 1'b1;
    if (bus.instr_op == 7'b0001110 || bus.instr_op == 7'b0001111 ||
        (bus.instr_op == 7'b0010001 && bus.sr_sel == 16'd0)) m_jmode = jb;
    if (leave) m_req = 0;
    if (enter) begin
      m_req = 0; m_hnd = 1;
      m_rt[0] = 1'b1; m_rt[2] = 1'b0;
      m_cause = m_vec;
      m_pend[m_vec[1:0]] = 1'b0;
      m_pc = bus.pc_ie ? bus.sr_in : (bus.pc_inc ? bus.pc_in + 16'd1 : bus.pc_in);
      m_shadow = old_flags;
    end
    if (ret) begin
      m_hnd = 0;
      m_rt[2] = 1'b1;
`ifdef SYSREG_IRQ_FLAG_SAVE_EN
      m_flags = m_shadow;
`endif
    end
    if (start) begin
      m_req = 1; m_vec = first;
    end
    m_pend = m_pend | (bus.irq_in & ~m_prev);
    m_prev = bus.irq_in;
  endtask

  function automatic logic [15:0] model_sr_out(input logic [15:0] sel, input logic ovr);
    if (ovr) return m_pc;
    case (sel)
      16'd1: return {13'd0, m_rt};
      16'd2: return {15'd0, m_jbuf};
      16'd3: return m_pc;
      16'd4: return {11'd0, m_flags};
      16'd5: return {12'd0, m_mask};
      16'd6: return {12'd0, m_pend};
      16'd7: return {12'd0, m_cause};
`ifdef SYSREG_IRQ_FLAG_SAVE_EN
      16'd8: return {11'd0, m_shadow};
`endif
      default: return 16'd0;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    model_update();
    model_on = 1;
  end

  initial forever begin
    @(negedge clk);
    if (model_on) begin
      check("model irq_req", 16'(bus.irq_req), 16'(m_req));
      check("model irq_vec", 16'(bus.irq_vec), 16'(m_vec));
      check("model irq_en", 16'(bus.irq_en), 16'(m_rt[2]));
      check("model instr_mem_over", 16'(bus.instr_mem_over), 16'(m_rt[1]));
      check("model boot_mode", 16'(bus.boot_mode), 16'(m_jmode));
      check("model alu_flags", 16'(bus.alu_flags), 16'(m_flags));
      check("model sr_out", bus.sr_out, model_sr_out(bus.sr_sel, bus.out_addr_ovr));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sr_wr(input logic [15:0] sel, input logic [15:0] data);
    bus.sr_ie = 1'b1; bus.sr_sel = sel; bus.sr_in = data;
    cyc();
    bus.sr_ie = 1'b0; bus.sr_in = '0;
  endtask

  task automatic peek(input string name, input logic [15:0] sel, input logic [15:0] exp);
    bus.sr_sel = sel;
    #1;
    check(name, bus.sr_out, exp);
  endtask

  task automatic ack(input logic [15:0] pc, input logic inc);
    bus.pc_in = pc; bus.pc_inc = inc; bus.irq_ack = 1'b1;
    cyc();
    bus.pc_in = '0; bus.pc_inc = 1'b0; bus.irq_ack = 1'b0;
  endtask

  task automatic do_iret();
    bus.instr_op = 7'b0001111;
    cyc();
    bus.instr_op = '0;
  endtask

  task automatic pulse(input logic [3:0] lines);
    bus.irq_in = lines;
    cyc();
    bus.irq_in = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.sr_ie = 0; bus.sr_sel = '0; bus.sr_in = '0; bus.instr_op = '0; bus.pc_in = '0;
    bus.pc_ie = 0; bus.pc_inc = 0; bus.out_addr_ovr = 0; bus.alu_flags_in = '0;
    bus.alu_flags_ie = 0; bus.irq_in = '0; bus.irq_ack = 0;
    cyc(); cyc();
    rst = 1'b0;

    // Reset state
    check("rst irq_req", 16'(bus.irq_req), 16'h0);
    check("rst irq_vec", 16'(bus.irq_vec), 16'h0);
    check("rst irq_en", 16'(bus.irq_en), 16'h0);
    check("rst boot_mode", 16'(bus.boot_mode), 16'h1);
    peek("rst SR1", 16'd1, 16'h0001);
    peek("rst SR2", 16'd2, 16'h0001);

    // Mask width, flag write priority
    sr_wr(16'd5, 16'hFFFF);
    peek("SR5 upper bits", 16'd5, 16'h000F);
    sr_wr(16'd1, 16'h0005);
    check("irq_en after SR1", 16'(bus.irq_en), 16'h1);
    bus.alu_flags_ie = 1'b1; bus.alu_flags_in = 5'h11;
    sr_wr(16'd4, 16'h0003);
    bus.alu_flags_ie = 1'b0;
    check("flags ie beats SR4", 16'(bus.alu_flags), 16'h0011);
    sr_wr(16'd4, 16'h0006);
    check("flags SR4 write", 16'(bus.alu_flags), 16'h0006);

    // Basic entry
    pulse(4'b0100);
    check("req before latency", 16'(bus.irq_req), 16'h0);
    cyc();
    check("req raised", 16'(bus.irq_req), 16'h1);
    check("vec 2", 16'(bus.irq_vec), 16'h2);
    ack(16'h0123, 1'b1);
    check("req after ack", 16'(bus.irq_req), 16'h0);
    check("irq_en in handler", 16'(bus.irq_en), 16'h0);
    peek("SR3 pc+1", 16'd3, 16'h0124);
    peek("SR7 cause", 16'd7, 16'h0002);
    peek("SR6 cleared", 16'd6, 16'h0000);
    do_iret();
    check("irq_en after iret", 16'(bus.irq_en), 16'h1);

    // Boot mode load paths
    sr_wr(16'd2, 16'h0000);
    check("boot holds on buff write", 16'(bus.boot_mode), 16'h1);
    bus.instr_op = 7'b0001110; cyc(); bus.instr_op = '0;
    check("boot loads 0", 16'(bus.boot_mode), 16'h0);
    sr_wr(16'd2, 16'h0001);
    bus.sr_sel = 16'd1; bus.instr_op = 7'b0010001; cyc();
    check("boot no load sel!=0", 16'(bus.boot_mode), 16'h0);
    bus.sr_sel = 16'd0; cyc(); bus.instr_op = '0;
    check("boot load sel=0", 16'(bus.boot_mode), 16'h1);

    // Priority, vec order, pc_ie capture
    pulse(4'b1010);
    cyc();
    check("vec 1 first", 16'(bus.irq_vec), 16'h1);
    bus.pc_ie = 1'b1; bus.sr_in = 16'hBEEF;
    ack(16'h0000, 1'b1);
    bus.pc_ie = 1'b0; bus.sr_in = '0;
    peek("SR3 pc_ie", 16'd3, 16'hBEEF);
    peek("SR6 bit3 left", 16'd6, 16'h0008);
    do_iret();
    check("no entry on iret cycle", 16'(bus.irq_req), 16'h0);
    cyc();
    check("vec 3 next", 16'(bus.irq_vec), 16'h3);
    pulse(4'b0001);
    cyc();
    check("vec stable in REQ", 16'(bus.irq_vec), 16'h3);

    // Withdraw by clearing IRQEN
    sr_wr(16'd1, 16'h0001);
    cyc();
    check("req withdrawn", 16'(bus.irq_req), 16'h0);
    peek("SR6 both pending", 16'd6, 16'h0009);
    bus.out_addr_ovr = 1'b1;
    peek("ovr forces irq_pc", 16'd5, 16'hBEEF);
    cyc();
    bus.out_addr_ovr = 1'b0;
    check("ovr sets IRQEN", 16'(bus.irq_en), 16'h1);
    cyc();
    check("vec 0", 16'(bus.irq_vec), 16'h0);
    ack(16'hFFFF, 1'b1);
    peek("SR3 wrap", 16'd3, 16'h0000);
    peek("SR7 cause 0", 16'd7, 16'h0000);
    do_iret();
    cyc();
    check("vec 3 again", 16'(bus.irq_vec), 16'h3);
    ack(16'h0042, 1'b0);
    peek("SR3 plain pc", 16'd3, 16'h0042);
    do_iret();

    // Set beats W1C
    bus.irq_in = 4'b0001;
    sr_wr(16'd6, 16'h0001);
    bus.irq_in = '0;
    peek("set beats clear", 16'd6, 16'h0001);
    cyc();
    check("req before rst", 16'(bus.irq_req), 16'h1);

    // Reset during REQ
    rst = 1'b1; cyc(); rst = 1'b0;
    check("rst abort req", 16'(bus.irq_req), 16'h0);
    check("rst abort irq_en", 16'(bus.irq_en), 16'h0);
    peek("rst abort SR6", 16'd6, 16'h0000);

    // Flag save/restore
    sr_wr(16'd5, 16'h000F);
    sr_wr(16'd4, 16'h000A);
    sr_wr(16'd1, 16'h0005);
    pulse(4'b0010);
    cyc();
    ack(16'h0000, 1'b0);
    bus.alu_flags_ie = 1'b1; bus.alu_flags_in = 5'h1F; cyc(); bus.alu_flags_ie = 1'b0;
    check("flags in handler", 16'(bus.alu_flags), 16'h001F);
    do_iret();
`ifdef SYSREG_IRQ_FLAG_SAVE_EN
    check("flags restored", 16'(bus.alu_flags), 16'h000A);
    peek("SR8 shadow", 16'd8, 16'h000A);
`else
    check("flags kept", 16'(bus.alu_flags), 16'h001F);
    peek("SR8 unmapped", 16'd8, 16'h0000);
`endif

    // SUP gating of SR1
    sr_wr(16'd1, 16'h0003);
    check("INA set", 16'(bus.instr_mem_over), 16'h1);
    sr_wr(16'd1, 16'h0000);
    sr_wr(16'd1, 16'h0007);
    peek("SR1 locked", 16'd1, 16'h0000);
    peek("SR0 unmapped", 16'd0, 16'h0000);
    peek("SR9 unmapped", 16'd9, 16'h0000);

    cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sysreg_irq.md
SYSREG_IRQ -- requirements
Module: sysreg_irq

Interface
REQ-001 SHALL have parameter IRQ_CNT, default 4 (legal 1..16), number of interrupt lines.
REQ-002 SHALL have parameter FLAGS_W, default 5, ALU flag width.
REQ-003 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset); one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports sr_ie (in, 1, SR write), sr_sel (in, 16, SR index), sr_in (in, 16, write data), sr_out (out, 16, read data).
REQ-005 SHALL have ports instr_op (in, 7, current opcode), pc_in (in, 16), pc_ie (in, 1), pc_inc (in, 1), out_addr_ovr (in, 1).
REQ-006 SHALL have ports alu_flags_in (in, FLAGS_W), alu_flags_ie (in, 1), alu_flags (out, FLAGS_W).
REQ-007 SHALL have ports irq_in (in, IRQ_CNT, level lines), irq_ack (in, 1, PC took vector), irq_req (out, 1), irq_vec (out, 4).
REQ-008 SHALL have outputs boot_mode, instr_mem_over, irq_en (1 bit each).

Function
REQ-009 SR map: 1 rt_mode[2:0] {IRQEN,INA,SUP}; 2 jtr_buff; 3 irq_pc; 4 alu_flags; 5 irq_mask[IRQ_CNT-1:0]; 6 irq_pend (write-1-to-clear); 7 irq_cause (read-only, zero-extended).
REQ-010 SR1 write SHALL take effect only when SUP=1; otherwise ignored.
REQ-011 jtr_mode SHALL load jtr_buff when instr_op is 0001110 or 0001111, or 0010001 with sr_sel=0; boot_mode=jtr_mode.
REQ-012 instr_mem_over=rt_mode[1]; irq_en=rt_mode[2].
REQ-013 out_addr_ovr=1 SHALL set IRQEN next cycle and force sr_out=irq_pc; else sr_out muxes REQ-009 registers, 0 for unmapped.
REQ-014 Each irq_in bit: rising edge (vs. registered previous sample) SHALL set matching irq_pend bit next cycle.
REQ-015 Same-cycle edge set and SR6 write-1-clear of one bit: set wins.
REQ-016 FSM states IDLE, REQ, ACTIVE.
REQ-017 IDLE->REQ when IRQEN=1 and (irq_pend & irq_mask)!=0; irq_vec latched = lowest set index; irq_req=1 throughout REQ, 0 otherwise.
REQ-018 In REQ, irq_vec SHALL stay stable; newer higher-priority pending SHALL NOT change it.
REQ-019 REQ with IRQEN cleared by SR1 write before irq_ack: return to IDLE, irq_req deasserted.
REQ-020 REQ+irq_ack -> ACTIVE in same edge: SUP=1, IRQEN=0, irq_cause=irq_vec, pend[irq_vec] cleared, irq_pc = sr_in if pc_ie, else pc_in+1 if pc_inc, else pc_in (16-bit wrap).
REQ-021 ACTIVE + instr_op=0001111 (iret) -> IDLE, IRQEN=1; new entry no earlier than next cycle.
REQ-022 alu_flags_ie SHALL load alu_flags_in; simultaneous SR4 write: alu_flags_ie wins.
REQ-023 Pend/mask bits above IRQ_CNT-1 SHALL read 0 and ignore writes.

Reset
REQ-024 On rst: rt_mode=001, jtr_mode=jtr_buff=1, irq_pc=0, alu_flags=0, irq_mask=0, irq_pend=0, irq_cause=0, edge samples=0, FSM=IDLE, irq_req=0, irq_vec=0.
REQ-025 rst asserted in REQ or ACTIVE SHALL abort to IDLE with no pending retained.

Configuration
REQ-026 Macro SYSREG_IRQ_FLAG_SAVE_EN defined: on ACTIVE entry alu_flags copied to shadow; on iret alu_flags restored from shadow (over alu_flags_ie); shadow readable at SR8, reset 0.
REQ-027 Macro undefined: no shadow, SR8 reads 0, iret leaves alu_flags unchanged.

Verification
REQ-028 Reset, enable: SR5=0xF, SR1=0x5, pulse irq_in=0b0100 -> irq_req=1, irq_vec=2; irq_ack with pc_inc=1, pc_in=0x0123 -> SR3=0x0124, SR7=2, irq_en=0, SR6=0.
REQ-029 Edges on bits 3 and 1 same cycle, all masked in -> vec=1 first; after iret, vec=3 next.
REQ-030 SR1 write 0x0 from SUP=1, then SR1 write 0x7 -> rt_mode stays 000.
REQ-031 Bit 0 edge coincident with SR6 write 0x1 -> SR6 reads 0x1.
REQ-032 With macro: alu_flags=0x0A at entry, alu_flags_ie loads 0x1F in handler, iret -> alu_flags=0x0A; without macro stays 0x1F.
REQ-033 rst during REQ -> next cycle irq_req=0, SR6=0, irq_en=0.
